// File: rtl/fifo_index_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_index_arb_pkg
// Shared definitions for the FIFO index arbiter:
//   - arb_state_t  : controller state encoding (RUN = 0, DRAIN = 1)
//   - clog2_min1   : ceil(log2(value)), never less than 1
//   - rr_idx_width : width of a round-robin producer index
// -----------------------------------------------------------------------------
package fifo_index_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } arb_state_t;

  // Constant function: smallest w >= 1 with 2**w >= value.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int rr_idx_width(input int n);
    return clog2_min1(n);
  endfunction

endpackage

// File: rtl/fifo_index_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_index_rr_pick
// Combinational round-robin picker. Starting at rr_ptr and wrapping, returns
// the first index whose valid_req bit is set.
// Ports:
//   valid_req  in  num_req : producers with a live, nonzero request
//   rr_ptr     in  idx_w   : highest-priority index this cycle
//   pick_idx   out idx_w   : first valid index at or after rr_ptr
//   pick_valid out 1       : any valid request found
// -----------------------------------------------------------------------------
module fifo_index_rr_pick
  import fifo_index_arb_pkg::*;
#(
  parameter  int num_req = 4,
  localparam int idx_w   = rr_idx_width(num_req)
) (
  input  logic [num_req-1:0] valid_req,
  input  logic [idx_w-1:0]   rr_ptr,
  output logic [idx_w-1:0]   pick_idx,
  output logic               pick_valid
);

  always_comb begin
    int j;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    j          = 0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int k = 0; k < num_req; k++) begin
      // rr_ptr never exceeds num_req-1, so one conditional wrap suffices.
      j = int'(rr_ptr) + k;
      if (j >= num_req) j = j - num_req;
      if (!pick_valid && valid_req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = idx_w'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_index_arb.sv
// -----------------------------------------------------------------------------
// fifo_index_arb
// Sequences a shared FIFO index between num_req producers and one consumer.
// Grants at most one multi-entry push and one multi-entry pop per cycle, never
// letting occupancy leave 0..depth. A flush request drains the FIFO with
// maximal pops before normal service resumes.
// Ports:
//   clk        in  1                    : rising-edge clock
//   reset      in  1                    : asynchronous active-high reset
//   req        in  num_req              : per-producer push request
//   req_cnt    in  num_req*push_width   : producer i count at [i*push_width +: push_width]
//   pop_req    in  pop_width            : requested pop count (0 = none)
//   flush      in  1                    : drain request (level, sampled)
//   grant      out num_req              : one-hot push grant (registered)
//   push       out push_width           : granted push count (registered)
//   pop        out pop_width            : granted pop count (registered)
//   cnt        out cnt_reg_width        : occupancy after the registered push/pop
//   full       out 1                    : cnt == depth
//   empty      out 1                    : cnt == 0
//   flush_done out 1                    : one-cycle pulse when a drain completes
// -----------------------------------------------------------------------------
module fifo_index_arb
  import fifo_index_arb_pkg::*;
#(
  parameter  int depth                 = 16,
  parameter  int push_width            = 2,
  parameter  int pop_width             = 2,
  parameter  int num_req               = 4,
  parameter  int simultaneous_push_pop = 1,
  localparam int cnt_reg_width         = clog2_min1(depth + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [num_req-1:0]               req,
  input  logic [num_req*push_width-1:0]    req_cnt,
  input  logic [pop_width-1:0]             pop_req,
  input  logic                             flush,
  output logic [num_req-1:0]               grant,
  output logic [push_width-1:0]            push,
  output logic [pop_width-1:0]             pop,
  output logic [cnt_reg_width-1:0]         cnt,
  output logic                             full,
  output logic                             empty,
  output logic                             flush_done
);

  localparam int rr_w = rr_idx_width(num_req);

  // Arithmetic width wide enough for cnt - pop + push without wrap.
  localparam int max_w  = (cnt_reg_width > push_width)
                          ? ((cnt_reg_width > pop_width) ? cnt_reg_width : pop_width)
                          : ((push_width > pop_width) ? push_width : pop_width);
  localparam int calc_w = max_w + 1;

  localparam logic [calc_w-1:0] depth_c   = calc_w'(depth);
  localparam logic [calc_w-1:0] pop_max_c = calc_w'((1 << pop_width) - 1);

  // Registered state
  arb_state_t                 state_q, state_d;
  logic [rr_w-1:0]            rr_q, rr_d;
  logic [num_req-1:0]         grant_q, grant_d;
  logic [push_width-1:0]      push_q, push_d;
  logic [pop_width-1:0]       pop_q, pop_d;
  logic [cnt_reg_width-1:0]   cnt_q, cnt_d;
  logic                       done_q, done_d;

  // Candidate selection
  logic [num_req-1:0]         valid_req;
  logic [rr_w-1:0]            pick_idx;
  logic                       pick_valid;
  logic [push_width-1:0]      cand_cnt;

  // Decision arithmetic
  logic [calc_w-1:0]          cnt_w, cand_w, pop_req_w, pop_calc, push_calc;
  logic                       fit;

  // A zero-count request is treated exactly like no request.
  always_comb begin
    valid_req = '0;
    for (int i = 0; i < num_req; i++)
      valid_req[i] = req[i] && (req_cnt[i*push_width +: push_width] != '0);
  end

  fifo_index_rr_pick #(
    .num_req (num_req)
  ) u_pick (
    .valid_req  (valid_req),
    .rr_ptr     (rr_q),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_comb begin
    cand_cnt = '0;
    for (int i = 0; i < num_req; i++)
      if (int'(pick_idx) == i) cand_cnt = req_cnt[i*push_width +: push_width];
  end

  assign cnt_w     = calc_w'(cnt_q);
  assign cand_w    = calc_w'(cand_cnt);
  assign pop_req_w = calc_w'(pop_req);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = '0;
    done_d    = 1'b0;
    pop_calc  = '0;
    push_calc = '0;
    fit       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (flush) begin
          // A sampled flush pre-empts service: nothing is granted on the
          // edge that enters DRAIN.
          state_d = DRAIN;
        end else begin
          // Oversized pops are refused, never truncated.
          if (pop_req_w <= cnt_w) pop_calc = pop_req_w;

          // Only the first round-robin candidate is considered; if it does
          // not fit, it blocks everyone behind it so it cannot starve.
          if (pick_valid) begin
            if (simultaneous_push_pop != 0)
              fit = (cnt_w - pop_calc + cand_w) <= depth_c;
            else
              fit = (pop_calc == '0) && ((cnt_w + cand_w) <= depth_c);

            if (fit) begin
              push_calc = cand_w;
              for (int i = 0; i < num_req; i++)
                grant_d[i] = (int'(pick_idx) == i);
              rr_d = (int'(pick_idx) == num_req - 1) ? '0 : pick_idx + rr_w'(1);
            end
          end
        end
      end

      DRAIN: begin
        pop_calc = (cnt_w < pop_max_c) ? cnt_w : pop_max_c;
        // Leaves when this pop empties the FIFO (also covers entry at cnt 0).
        if (cnt_w == pop_calc) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
    endcase

    pop_d  = pop_calc[pop_width-1:0];
    push_d = push_calc[push_width-1:0];
    cnt_d  = cnt_reg_width'(cnt_w + push_calc - pop_calc);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rr_q    <= '0;
      grant_q <= '0;
      push_q  <= '0;
      pop_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign grant      = grant_q;
  assign push       = push_q;
  assign pop        = pop_q;
  assign cnt        = cnt_q;
  assign flush_done = done_q;
  assign full       = (cnt_q == cnt_reg_width'(depth));
  assign empty      = (cnt_q == '0);

endmodule

// File: tb/tb_fifo_index_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_index_arb
// Drives two arbiters from the same inputs: u_dut1 allows a push and a pop in
// the same cycle, u_dut0 forbids it. A behavioural model per instance, written
// from the occupancy/round-robin rules with plain integers, is compared with
// every output after every clock edge. Directed scenarios pin the model with
// hand-computed literals; a random phase then exercises both instances.
// -----------------------------------------------------------------------------
module tb_fifo_index_arb;

  localparam int DEPTH = 16;
  localparam int NR    = 4;
  localparam int PMAX  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] req_cnt;
  logic [1:0] pop_req;
  logic       flush;

  logic [3:0] grant_o [2];
  logic [1:0] push_o  [2];
  logic [1:0] pop_o   [2];
  logic [4:0] cnt_o   [2];
  logic       full_o  [2];
  logic       empty_o [2];
  logic       done_o  [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 1 = simultaneous allowed, index 0 = forbidden
  int m_cnt   [2];
  int m_rr    [2];
  bit m_drain [2];
  int e_grant [2];
  int e_push  [2];
  int e_pop   [2];
  int e_done  [2];

  always #5 clk = ~clk;

  fifo_index_arb #(
    .depth(16), .push_width(2), .pop_width(2), .num_req(4), .simultaneous_push_pop(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .req_cnt(req_cnt), .pop_req(pop_req),
    .flush(flush), .grant(grant_o[1]), .push(push_o[1]), .pop(pop_o[1]),
    .cnt(cnt_o[1]), .full(full_o[1]), .empty(empty_o[1]), .flush_done(done_o[1])
  );

  fifo_index_arb #(
    .depth(16), .push_width(2), .pop_width(2), .num_req(4), .simultaneous_push_pop(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .req_cnt(req_cnt), .pop_req(pop_req),
    .flush(flush), .grant(grant_o[0]), .push(push_o[0]), .pop(pop_o[0]),
    .cnt(cnt_o[0]), .full(full_o[0]), .empty(empty_o[0]), .flush_done(done_o[0])
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] pack(input int c0, input int c1, input int c2, input int c3);
    logic [7:0] v;
    v = {2'(c3), 2'(c2), 2'(c1), 2'(c0)};
    return v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_cnt[u] = 0; m_rr[u] = 0; m_drain[u] = 1'b0;
      e_grant[u] = 0; e_push[u] = 0; e_pop[u] = 0; e_done[u] = 0;
    end
  endtask

  // One clock edge of the arbiter rules for instance u.
  task automatic model_step(input int u, input logic [3:0] r, input logic [7:0] rc,
                            input int preq, input logic fl);
    int p, cand, c, idx;
    bit ok;
    e_grant[u] = 0; e_push[u] = 0; e_pop[u] = 0; e_done[u] = 0;
    if (m_drain[u]) begin
      e_pop[u] = (m_cnt[u] < PMAX) ? m_cnt[u] : PMAX;
      m_cnt[u] = m_cnt[u] - e_pop[u];
      if (m_cnt[u] == 0) begin
        m_drain[u] = 1'b0;
        e_done[u]  = 1;
      end
    end else if (fl) begin
      m_drain[u] = 1'b1;
    end else begin
      p = (preq <= m_cnt[u]) ? preq : 0;
      cand = -1;
      c = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr[u] + k) % NR;
        if (r[idx] && ((rc >> (2 * idx)) & 3) != 0) begin
          cand = idx;
          c = int'((rc >> (2 * idx)) & 3);
          break;
        end
      end
      if (cand >= 0) begin
        if (u == 1) ok = (m_cnt[u] - p + c) <= DEPTH;
        else        ok = (p == 0) && (m_cnt[u] + c <= DEPTH);
        if (ok) begin
          e_grant[u] = 1 << cand;
          e_push[u]  = c;
          m_rr[u]    = (cand + 1) % NR;
        end
      end
      e_pop[u] = p;
      m_cnt[u] = m_cnt[u] + e_push[u] - p;
    end
  endtask

  task automatic compare_all();
    for (int u = 0; u < 2; u++) begin
      check($sformatf("d%0d grant", u), int'(grant_o[u]), e_grant[u]);
      check($sformatf("d%0d push", u),  int'(push_o[u]),  e_push[u]);
      check($sformatf("d%0d pop", u),   int'(pop_o[u]),   e_pop[u]);
      check($sformatf("d%0d cnt", u),   int'(cnt_o[u]),   m_cnt[u]);
      check($sformatf("d%0d full", u),  int'(full_o[u]),  int'(m_cnt[u] == DEPTH));
      check($sformatf("d%0d empty", u), int'(empty_o[u]), int'(m_cnt[u] == 0));
      check($sformatf("d%0d flush_done", u), int'(done_o[u]), e_done[u]);
    end
  endtask

  // Drive at the falling edge, advance the model at the rising edge, compare
  // the registered outputs 1 ns later.
  task automatic step(input logic [3:0] r, input logic [7:0] rc,
                      input logic [1:0] pr, input logic fl);
    @(negedge clk);
    req = r; req_cnt = rc; pop_req = pr; flush = fl;
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_step(u, r, rc, int'(pr), fl);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; req = '0; req_cnt = '0; pop_req = '0; flush = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset grant", int'(grant_o[1]), 0);
    check("reset pop",   int'(pop_o[1]),   0);
    check("reset cnt",   int'(cnt_o[1]),   0);
    check("reset empty", int'(empty_o[1]), 1);
    check("reset full",  int'(full_o[1]),  0);
    check("reset done",  int'(done_o[0]),  0);

    // Producer 2 pushes 3 into an empty FIFO
    step(4'b0100, pack(0, 0, 3, 0), 2'd0, 1'b0);
    check("s1 grant", int'(grant_o[1]), 4'b0100);
    check("s1 push",  int'(push_o[1]),  3);
    check("s1 cnt",   int'(cnt_o[1]),   3);
    // rr pointer now 3: producer 3 beats producer 0
    step(4'b1001, pack(1, 0, 0, 1), 2'd0, 1'b0);
    check("s2 rr grant", int'(grant_o[1]), 4'b1000);
    step(4'b0001, pack(3, 0, 0, 0), 2'd0, 1'b0);
    step(4'b0010, pack(0, 3, 0, 0), 2'd0, 1'b0);
    step(4'b0100, pack(0, 0, 3, 0), 2'd0, 1'b0);
    step(4'b1000, pack(0, 0, 0, 2), 2'd0, 1'b0);
    check("s6 cnt", int'(cnt_o[1]), 15);
    // Unfit head candidate blocks producer 1
    step(4'b0011, pack(2, 1, 0, 0), 2'd0, 1'b0);
    check("s7 blocked grant", int'(grant_o[1]), 0);
    check("s7 cnt", int'(cnt_o[1]), 15);
    // With a pop of 2 it fits only when simultaneous is allowed
    step(4'b0011, pack(2, 1, 0, 0), 2'd2, 1'b0);
    check("s8 d1 grant", int'(grant_o[1]), 4'b0001);
    check("s8 d1 push",  int'(push_o[1]),  2);
    check("s8 d1 pop",   int'(pop_o[1]),   2);
    check("s8 d1 cnt",   int'(cnt_o[1]),   15);
    check("s8 d0 grant", int'(grant_o[0]), 0);
    check("s8 d0 cnt",   int'(cnt_o[0]),   13);
    step(4'b0000, '0, 2'd3, 1'b0);
    step(4'b0000, '0, 2'd3, 1'b0);
    step(4'b0000, '0, 2'd2, 1'b0);
    check("s11 d0 cnt", int'(cnt_o[0]), 5);
    // Pop has priority when simultaneous is forbidden
    step(4'b1000, pack(0, 0, 0, 1), 2'd1, 1'b0);
    check("s12 d0 pop",   int'(pop_o[0]),   1);
    check("s12 d0 grant", int'(grant_o[0]), 0);
    step(4'b1000, pack(0, 0, 0, 1), 2'd0, 1'b0);
    check("s13 d0 grant", int'(grant_o[0]), 4'b1000);
    check("s13 d0 cnt",   int'(cnt_o[0]),   5);
    step(4'b0000, '0, 2'd3, 1'b0);
    // Oversized pop (3 > 2) refused
    step(4'b0000, '0, 2'd3, 1'b0);
    check("s15 d0 pop",   int'(pop_o[0]),   0);
    check("s15 d0 cnt",   int'(cnt_o[0]),   2);
    check("s15 d0 empty", int'(empty_o[0]), 0);
    step(4'b0001, pack(3, 0, 0, 0), 2'd0, 1'b0);
    step(4'b0010, pack(0, 2, 0, 0), 2'd0, 1'b0);
    check("s17 cnt", int'(cnt_o[1]), 7);
    // Flush from cnt 7: pops 3,3,1, requests ignored
    step(4'b1111, pack(3, 3, 3, 3), 2'd3, 1'b1);
    check("s18 pop",   int'(pop_o[1]),   0);
    check("s18 grant", int'(grant_o[1]), 0);
    step(4'b1111, pack(3, 3, 3, 3), 2'd0, 1'b0);
    check("s19 pop", int'(pop_o[1]), 3);
    check("s19 cnt", int'(cnt_o[1]), 4);
    step(4'b1111, pack(3, 3, 3, 3), 2'd0, 1'b0);
    check("s20 pop", int'(pop_o[1]), 3);
    step(4'b1111, pack(3, 3, 3, 3), 2'd0, 1'b0);
    check("s21 pop",   int'(pop_o[1]),   1);
    check("s21 done",  int'(done_o[1]),  1);
    check("s21 empty", int'(empty_o[1]), 1);
    check("s21 grant", int'(grant_o[1]), 0);
    // Flush held: re-entry, then immediate completion at cnt 0
    step(4'b0000, '0, 2'd0, 1'b1);
    step(4'b0000, '0, 2'd0, 1'b1);
    check("s23 done", int'(done_o[0]), 1);
    step(4'b0000, '0, 2'd0, 1'b1);
    step(4'b0000, '0, 2'd0, 1'b0);
    // Refill to 7, start a drain, reset asynchronously at cnt 4
    step(4'b0100, pack(0, 0, 3, 0), 2'd0, 1'b0);
    step(4'b1000, pack(0, 0, 0, 3), 2'd0, 1'b0);
    step(4'b0001, pack(1, 0, 0, 0), 2'd0, 1'b0);
    step(4'b0000, '0, 2'd0, 1'b1);
    step(4'b0000, '0, 2'd0, 1'b0);
    check("s30 cnt", int'(cnt_o[1]), 4);
    #3;
    reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("arst d%0d cnt", u),   int'(cnt_o[u]),   0);
      check($sformatf("arst d%0d pop", u),   int'(pop_o[u]),   0);
      check($sformatf("arst d%0d grant", u), int'(grant_o[u]), 0);
      check($sformatf("arst d%0d push", u),  int'(push_o[u]),  0);
      check($sformatf("arst d%0d empty", u), int'(empty_o[u]), 1);
      check($sformatf("arst d%0d done", u),  int'(done_o[u]),  0);
    end
    model_reset();
    @(posedge clk);
    #1;
    check("arst held done", int'(done_o[1]), 0);
    @(negedge clk);
    reset = 1'b0;
    // After reset the machine is back in RUN: a push is granted directly
    step(4'b0010, pack(0, 2, 0, 0), 2'd0, 1'b0);
    check("post rst grant", int'(grant_o[1]), 4'b0010);

    // Random phase: alternate push-heavy and pop-heavy windows
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      logic [7:0] rc;
      logic [1:0] pr;
      logic       fl;
      r  = 4'($urandom);
      rc = 8'($urandom);
      if (((n / 150) % 2) == 0) pr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
      else                      pr = 2'($urandom);
      fl = ($urandom_range(0, 39) == 0);
      step(r, rc, pr, fl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_index_arb.md
# fifo_index_arb

Controller that sequences a shared FIFO index between `num_req` producers and one consumer. It grants at most one multi-entry push and one multi-entry pop per cycle, and only ever issues push/pop counts that keep occupancy within 0..depth. As a result, a downstream FIFO-index checker never sees an overflow, underflow or illegal simultaneous push/pop from this block. It also provides a flush sequence that drains the FIFO before returning to normal service.

## Interface
- `depth`, 16: FIFO capacity in entries; must be ≥ 1.
- `push_width`, 2: width of each producer's push count.
- `pop_width`, 2: width of the pop count.
- `num_req`, 4: number of producers, 2..16.
- `simultaneous_push_pop`, 1: 1 allows a push and a pop in the same cycle; 0 forbids it.
- `cnt_reg_width`, derived: ceil(log2(depth+1)), minimum 1.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  num_req: per-producer push request.
- `req_cnt`  in  num_req*push_width: producer i's count in bits [i*push_width +: push_width].
- `pop_req`  in  pop_width: requested pop count; 0 means no pop.
- `flush`  in  1: request to drain the FIFO (level-sensitive, sampled).
- `grant`  out  num_req: one-hot push grant (registered).
- `push`  out  push_width: granted push count (registered).
- `pop`  out  pop_width: granted pop count (registered).
- `cnt`  out  cnt_reg_width: occupancy after the registered push/pop.
- `full`  out  1: cnt == depth.
- `empty`  out  1: cnt == 0.
- `flush_done`  out  1: one-cycle pulse when a drain completes.

## Operation
- **States:** RUN and DRAIN.
  - RUN → DRAIN when `flush` is sampled high.
  - DRAIN → RUN when the drain pop makes next cnt == 0, or when cnt is already 0 on entry. `flush_done` pulses on that transition edge.
- **Pop decision** (RUN): p = `pop_req` if `pop_req` ≤ cnt, else 0. An oversized pop is refused outright, never truncated.
- **Push candidate** (RUN): scan round-robin from pointer `rr_ptr` for the first i with `req[i]` high and a nonzero count.
  - Zero-count requests are skipped as if not requesting.
  - Only that first candidate is evaluated; an unfit request blocks lower priorities. This prevents starvation of large requests.
- **Push fit:**
  - With `simultaneous_push_pop`=1: fits if cnt − p + c ≤ depth.
  - With `simultaneous_push_pop`=0: fits only if p == 0. Pop has priority, so the candidate waits while a pop is granted.
- **On a push grant:** `grant`=onehot(i), `push`=c, and `rr_ptr` ← (i+1) mod num_req. With no grant, `rr_ptr` is held.
- **Count update:** next cnt = cnt + push − pop, computed in cnt_reg_width+1 bits. By construction it stays within 0..depth.
- **DRAIN state:**
  - No push grants; `req` is ignored.
  - Each cycle pop = min(cnt, 2^pop_width − 1), irrespective of `pop_req`.
  - `flush` held high after done causes re-entry to DRAIN on the next cycle.
- **Reset values:** cnt=0, `rr_ptr`=0, state=RUN, `grant`=0, `push`=0, `pop`=0, `flush_done`=0, `full`=0, `empty`=1 (`empty` is 1 because cnt=0).

## Timing
- Requests are sampled at edge t. `grant`/`push`/`pop`/`cnt` reflect the decision after edge t, so latency is 1 cycle.
- Outputs are valid for exactly one cycle. Requesters must hold `req` until they see `grant`.
- `full`/`empty` are combinational from the registered cnt.
- `reset` mid-operation immediately clears all state, including a DRAIN in progress. No `flush_done` is issued.
- Deassertion of `reset` is synchronised externally. The first decision is made at the first edge after release.

## Structure
- Package `fifo_index_arb_pkg` holds:
  - the state encoding (RUN=0, DRAIN=1);
  - the ceil-log2 constant function used for `cnt_reg_width`;
  - the round-robin index width function.
- Sub-module `fifo_index_rr_pick`: combinational. Given `req & (req_cnt != 0)` and `rr_ptr`, it returns the first index and a valid flag.
- The top level holds the FSM, counter, fit logic and output registers.

## Test plan
- depth=16, cnt=0; producer 2 requests 3, `pop_req`=0 → next cycle grant=0100, push=3, cnt=3; `rr_ptr`=3.
- cnt=15; producer 0 requests 2 and producer 1 requests 1, `rr_ptr`=0 → no grant (producer 1 is not skipped to). With `pop_req`=2 and simultaneous=1 → pop=2, push=2, cnt=15.
- simultaneous=0, cnt=5, `pop_req`=1, producer 3 requests 1 → pop=1, grant=0; next cycle grant=1000, cnt=5.
- cnt=2, `pop_req`=3 → pop=0, cnt stays 2; `empty` stays 0.
- cnt=7, `flush` pulse, `pop_width`=2 → pops 3,3,1 on consecutive cycles; `flush_done` pulses with cnt=0; all `req` ignored meanwhile.
- Assert `reset` asynchronously mid-DRAIN with cnt=4 → cnt=0, state RUN, all outputs 0 immediately, `empty`=1, no `flush_done`.
